alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_pkg.sv | 30 +++
 rtl/alu_issue_dec.sv | 83 ++++++++
 rtl/alu_issue.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: 4-bit ALU operation codes,
// RV32I opcodes used by the decoder, and the issue-stage state enumeration.
package alu_issue_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLL = 4'b0101;
   localparam logic [3:0] ALU_SRL = 4'b0110;
   localparam logic [3:0] ALU_SRA = 4'b0111;
   localparam logic [3:0] ALU_SLT = 4'b1000;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   function automatic logic [31:0] sext12(input logic [11:0] imm);
      return {{20{imm[11]}}, imm};
   endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational RV32I OP/OP-IMM decoder producing ALU operands, code, rd and
// an illegal flag. ALU_ISSUE_SHAMT_CHECK_EN enables strict I-type shift funct7 checks.
module alu_issue_dec
   import alu_issue_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output logic [31:0] a,
   output logic [31:0] b,
   output logic [3:0]  ctrl,
   output logic [4:0]  rd,
   output logic        illegal
);

   logic [6:0]  opcode_s;
   logic [2:0]  funct3_s;
   logic [6:0]  funct7_s;
   logic        is_r_s;
   logic        is_i_s;
   logic [4:0]  shamt_s;
   logic [31:0] b_raw_s;
   logic [3:0]  ctrl_raw_s;
   logic        sh_bad_s;
   logic        unused_rs1_field_s;

   assign unused_rs1_field_s = ^instr[19:15];

   // Field extraction, operation selection and legality
   always_comb begin
      opcode_s   = instr[6:0];
      funct3_s   = instr[14:12];
      funct7_s   = instr[31:25];
      is_r_s     = (opcode_s == OPC_OP);
      is_i_s     = (opcode_s == OPC_OP_IMM);
      shamt_s    = is_r_s ? rs2_data[4:0] : instr[24:20];
      b_raw_s    = is_r_s ? rs2_data : sext12(instr[31:20]);
      ctrl_raw_s = ALU_ADD;
      case (funct3_s)
         3'b000: ctrl_raw_s = (is_r_s && (funct7_s == F7_ALT)) ? ALU_SUB : ALU_ADD;
         3'b111: ctrl_raw_s = ALU_AND;
         3'b110: ctrl_raw_s = ALU_OR;
         3'b100: ctrl_raw_s = ALU_XOR;
         3'b010: ctrl_raw_s = ALU_SLT;
         3'b001: begin
            ctrl_raw_s = ALU_SLL;
            b_raw_s    = {27'd0, shamt_s};
         end
         3'b101: begin
            ctrl_raw_s = instr[30] ? ALU_SRA : ALU_SRL;
            b_raw_s    = {27'd0, shamt_s};
         end
         default: ctrl_raw_s = ALU_ADD;
      endcase

`ifdef ALU_ISSUE_SHAMT_CHECK_EN
      sh_bad_s = is_i_s &&
                 (((funct3_s == 3'b001) && (funct7_s != F7_BASE)) ||
                  ((funct3_s == 3'b101) && (funct7_s != (instr[30] ? F7_ALT : F7_BASE))));
`else
      sh_bad_s = 1'b0;
`endif

      illegal = (!is_r_s && !is_i_s) ||
                (funct3_s == 3'b011) ||
                (is_r_s && (funct7_s != F7_BASE) && (funct7_s != F7_ALT)) ||
                (is_r_s && (funct7_s == F7_ALT) && (funct3_s != 3'b000) && (funct3_s != 3'b101)) ||
                sh_bad_s;

      if (illegal) begin
         a    = 32'd0;
         b    = 32'd0;
         ctrl = ALU_ADD;
         rd   = 5'd0;
      end else begin
         a    = rs1_data;
         b    = b_raw_s;
         ctrl = ctrl_raw_s;
         rd   = instr[11:7];
      end
   end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: accepts an instruction, drives registered operands to an
// external ALU, captures its response and presents it on a valid/ready port.
// Build option: ALU_ISSUE_SHAMT_CHECK_EN (strict I-type shift encoding checks).
module alu_issue
   import alu_issue_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_ctrl,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_zero,
   output logic [4:0]  out_rd,
   output logic        out_illegal
);

   logic [31:0] dec_a_s;
   logic [31:0] dec_b_s;
   logic [3:0]  dec_ctrl_s;
   logic [4:0]  dec_rd_s;
   logic        dec_illegal_s;
   logic        in_ready_s;
   logic        accept_s;

   state_e      state_q,       state_d;
   logic [31:0] alu_a_q,       alu_a_d;
   logic [31:0] alu_b_q,       alu_b_d;
   logic [3:0]  alu_ctrl_q,    alu_ctrl_d;
   logic [4:0]  rd_q,          rd_d;
   logic        illegal_q,     illegal_d;
   logic        out_valid_q,   out_valid_d;
   logic [31:0] out_result_q,  out_result_d;
   logic        out_zero_q,    out_zero_d;
   logic [4:0]  out_rd_q,      out_rd_d;
   logic        out_illegal_q, out_illegal_d;

   alu_issue_dec u_dec (
      .instr    (instr),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .a        (dec_a_s),
      .b        (dec_b_s),
      .ctrl     (dec_ctrl_s),
      .rd       (dec_rd_s),
      .illegal  (dec_illegal_s)
   );

   // Next-state, handshake and datapath capture
   always_comb begin
      state_d       = state_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      alu_ctrl_d    = alu_ctrl_q;
      rd_d          = rd_q;
      illegal_d     = illegal_q;
      out_valid_d   = out_valid_q;
      out_result_d  = out_result_q;
      out_zero_d    = out_zero_q;
      out_rd_d      = out_rd_q;
      out_illegal_d = out_illegal_q;
      in_ready_s    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            in_ready_s = 1'b1;
            state_d    = in_valid ? ST_EXEC : ST_IDLE;
         end
         ST_EXEC: begin
            in_ready_s    = 1'b0;
            state_d       = ST_DONE;
            out_valid_d   = 1'b1;
            out_result_d  = illegal_q ? 32'd0 : alu_result;
            out_zero_d    = illegal_q ? 1'b1 : alu_zero;
            out_rd_d      = rd_q;
            out_illegal_d = illegal_q;
         end
         ST_DONE: begin
            in_ready_s = out_ready;
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = in_valid ? ST_EXEC : ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            in_ready_s  = 1'b0;
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase

      accept_s = in_valid && in_ready_s;
      if (accept_s) begin
         alu_a_d    = dec_a_s;
         alu_b_d    = dec_b_s;
         alu_ctrl_d = dec_ctrl_s;
         rd_d       = dec_rd_s;
         illegal_d  = dec_illegal_s;
      end else begin
         alu_a_d    = alu_a_q;
         alu_b_d    = alu_b_q;
         alu_ctrl_d = alu_ctrl_q;
         rd_d       = rd_q;
         illegal_d  = illegal_q;
      end
   end

   // State and output registers; reset discards any in-flight operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         alu_a_q       <= 32'd0;
         alu_b_q       <= 32'd0;
         alu_ctrl_q    <= ALU_ADD;
         rd_q          <= 5'd0;
         illegal_q     <= 1'b0;
         out_valid_q   <= 1'b0;
         out_result_q  <= 32'd0;
         out_zero_q    <= 1'b1;
         out_rd_q      <= 5'd0;
         out_illegal_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         alu_ctrl_q    <= alu_ctrl_d;
         rd_q          <= rd_d;
         illegal_q     <= illegal_d;
         out_valid_q   <= out_valid_d;
         out_result_q  <= out_result_d;
         out_zero_q    <= out_zero_d;
         out_rd_q      <= out_rd_d;
         out_illegal_q <= out_illegal_d;
      end
   end

   assign in_ready    = in_ready_s;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_ctrl    = alu_ctrl_q;
   assign out_valid   = out_valid_q;
   assign out_result  = out_result_q;
   assign out_zero    = out_zero_q;
   assign out_rd      = out_rd_q;
   assign out_illegal = out_illegal_q;

endmodule
